// File: rtl/wsp_instr_loader.sv
// Wrapper serial port WIR loader: capture/shift/update sequencer.
// Define WIR_READBACK_EN to collect the old WIR contents on readback.
module wsp_instr_loader #(
    parameter int IR_LEN = 12
) (
    input  logic              WRCK,
    input  logic              WRST,
    input  logic              start,
    input  logic              abort,
    input  logic [IR_LEN-1:0] instr,
    input  logic              WSO,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              SelectWIR,
    output logic              CaptureWR,
    output logic              ShiftWR,
    output logic              UpdateWR,
    output logic              WSI,
    output logic [IR_LEN-1:0] readback
);

    localparam int CW = $clog2(IR_LEN);
    localparam logic [CW-1:0] LAST = CW'(IR_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        UPDATE,
        DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [IR_LEN-1:0] instr_q;

    assign cnt_nxt = cnt + CW'(1);

    always_ff @(posedge WRCK or posedge WRST) begin
        if (WRST) begin
            state     <= IDLE;
            cnt       <= '0;
            instr_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            SelectWIR <= 1'b0;
            CaptureWR <= 1'b0;
            ShiftWR   <= 1'b0;
            UpdateWR  <= 1'b0;
            WSI       <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= CAPTURE;
                        instr_q   <= instr;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        SelectWIR <= 1'b1;
                        CaptureWR <= 1'b1;
                    end
                end
                CAPTURE, SHIFT: begin
                    if (abort) begin
                        // Cancel before UpdateWR so the WIR keeps its old code
                        state     <= IDLE;
                        busy      <= 1'b0;
                        aborted   <= 1'b1;
                        SelectWIR <= 1'b0;
                        CaptureWR <= 1'b0;
                        ShiftWR   <= 1'b0;
                        WSI       <= 1'b0;
                    end else if (state == CAPTURE) begin
                        state     <= SHIFT;
                        CaptureWR <= 1'b0;
                        ShiftWR   <= 1'b1;
                        WSI       <= instr_q[0];
                    end else if (cnt == LAST) begin
                        state    <= UPDATE;
                        ShiftWR  <= 1'b0;
                        UpdateWR <= 1'b1;
                        WSI      <= 1'b0;
                    end else begin
                        cnt <= cnt_nxt;
                        WSI <= instr_q[cnt_nxt];
                    end
                end
                UPDATE: begin
                    state     <= DONE;
                    UpdateWR  <= 1'b0;
                    SelectWIR <= 1'b0;
                    done      <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    SelectWIR <= 1'b0;
                    CaptureWR <= 1'b0;
                    ShiftWR   <= 1'b0;
                    UpdateWR  <= 1'b0;
                    WSI       <= 1'b0;
                end
            endcase
        end
    end

`ifdef WIR_READBACK_EN
    logic [IR_LEN-1:0] rb_q;

    // First bit out of the WIR ends up in bit 0 after a full shift
    always_ff @(posedge WRCK or posedge WRST) begin
        if (WRST) begin
            rb_q <= '0;
        end else if (state == SHIFT) begin
            rb_q <= {WSO, rb_q[IR_LEN-1:1]};
        end
    end

    assign readback = rb_q;
`else
    logic unused_wso;

    assign unused_wso = WSO;
    assign readback   = '0;
`endif

endmodule

// File: tb/tb_wsp_instr_loader.sv
// Directed bench for wsp_instr_loader with a 12-bit behavioural WIR.
// Readback checks follow WIR_READBACK_EN.
module tb_wsp_instr_loader;

    localparam int N = 12;
    localparam logic [N-1:0] WIR_CAP = 12'hA5C;

    logic         WRCK;
    logic         WRST;
    logic         start;
    logic         abort;
    logic [N-1:0] instr;
    logic         WSO;
    logic         busy;
    logic         done;
    logic         aborted;
    logic         SelectWIR;
    logic         CaptureWR;
    logic         ShiftWR;
    logic         UpdateWR;
    logic         WSI;
    logic [N-1:0] readback;

    logic [7:0]   outs;
    logic [N-1:0] wir;
    logic [N-1:0] wir_upd;

    int n_chk  = 0;
    int n_fail = 0;

    wsp_instr_loader #(
        .IR_LEN(N)
    ) dut (
        .WRCK     (WRCK),
        .WRST     (WRST),
        .start    (start),
        .abort    (abort),
        .instr    (instr),
        .WSO      (WSO),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .SelectWIR(SelectWIR),
        .CaptureWR(CaptureWR),
        .ShiftWR  (ShiftWR),
        .UpdateWR (UpdateWR),
        .WSI      (WSI),
        .readback (readback)
    );

    assign outs = {busy, done, aborted, SelectWIR,
                   CaptureWR, ShiftWR, UpdateWR, WSI};

    initial WRCK = 1'b0;
    always #5 WRCK = ~WRCK;

    // Behavioural WIR: capture a fixed status word, shift LSB out
    initial wir_upd = '0;
    always @(posedge WRCK) begin
        if (CaptureWR)
            wir <= WIR_CAP;
        else if (ShiftWR)
            wir <= {WSI, wir[N-1:1]};
        if (UpdateWR)
            wir_upd <= wir;
    end
    assign WSO = wir[0];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge WRCK);
        #1;
    endtask

    // Expected {busy,done,aborted,Sel,Cap,Shift,Upd,WSI} in cycle c
    function automatic logic [7:0] exp_outs(input int c,
                                            input logic [N-1:0] code);
        if (c == 1)
            return 8'h98;
        else if (c >= 2 && c <= N + 1)
            return 8'h94 | {7'h0, code[c-2]};
        else if (c == N + 2)
            return 8'h92;
        else if (c == N + 3)
            return 8'hC0;
        return 8'h00;
    endfunction

    task automatic load_check(input string tag,
                              input logic [N-1:0] code,
                              input int poke);
        int n_done;
        n_done = 0;
        instr  = code;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 1; c <= N + 5; c++) begin
            check($sformatf("%s_c%0d", tag, c), {24'h0, outs},
                  {24'h0, exp_outs(c, code)});
            if (done)
                n_done++;
            if (c == poke) begin
                start = 1'b1;
                instr = 12'hFFF;
            end else if (c == poke + 1) begin
                start = 1'b0;
            end
            tick();
        end
        check({tag, "_ndone"}, n_done, 1);
        check({tag, "_wir"}, {20'h0, wir_upd}, {20'h0, code});
`ifdef WIR_READBACK_EN
        check({tag, "_rb"}, {20'h0, readback}, {20'h0, WIR_CAP});
`else
        check({tag, "_rb"}, {20'h0, readback}, 32'h0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int d1;
        int c2;
        int n_upd;
        int n_done;

        WRST  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        instr = '0;
        #1 WRST = 1'b1;
        #10;
        check("rst_outs", {24'h0, outs}, 32'h0);
        check("rst_rb", {20'h0, readback}, 32'h0);
        WRST = 1'b0;

        load_check("basic", 12'b010010010010, 0);
        load_check("busy_start", 12'h492, 6);

        // start and abort together in IDLE: abort wins
        instr = 12'h492;
        start = 1'b1;
        abort = 1'b1;
        tick();
        check("start_abort_idle", {24'h0, outs}, 32'h0);
        start = 1'b0;
        abort = 1'b0;

        // start held high: back-to-back loads
        c1 = -1;
        d1 = -1;
        c2 = -1;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 40; c++) begin
            if (CaptureWR && c1 < 0)
                c1 = c;
            if (CaptureWR && d1 >= 0 && c2 < 0)
                c2 = c;
            if (done && d1 < 0)
                d1 = c;
            tick();
        end
        start = 1'b0;
        check("b2b_first_cap", c1, 1);
        check("b2b_first_done", d1, 15);
        check("b2b_gap", c2 - d1, 2);
        for (int i = 0; i < 40 && busy; i++)
            tick();
        check("b2b_drain", {31'h0, busy}, 32'h0);

        // abort sampled at the end of shift cycle 5 (cycle 6)
        instr = 12'h492;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++)
            tick();
        check("abort_in_shift", {24'h0, outs}, {24'h0, exp_outs(6, 12'h492)});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_pulse", {24'h0, outs}, 32'h20);
`ifdef WIR_READBACK_EN
        check("abort_rb", {20'h0, readback}, 32'hE52);
`endif
        n_upd  = 0;
        n_done = 0;
        tick();
        check("abort_after", {24'h0, outs}, 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (UpdateWR)
                n_upd++;
            if (done)
                n_done++;
            tick();
        end
        check("abort_no_upd", n_upd, 0);
        check("abort_no_done", n_done, 0);
`ifdef WIR_READBACK_EN
        check("abort_rb_hold", {20'h0, readback}, 32'hE52);
`endif

        // asynchronous reset in cycle 8
        instr = 12'h492;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++)
            tick();
        check("pre_rst", {24'h0, outs}, {24'h0, exp_outs(8, 12'h492)});
        #2 WRST = 1'b1;
        #1;
        check("midrst_outs", {24'h0, outs}, 32'h0);
        check("midrst_rb", {20'h0, readback}, 32'h0);
        n_upd = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (UpdateWR || done)
                n_upd++;
        end
        check("midrst_no_upd", n_upd, 0);
        #2 WRST = 1'b0;
        load_check("post_rst", 12'h3A6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
